// File: rtl/nibble_serial_adder.sv
// Serial WIDTH-bit adder: one 4-bit carry-lookahead slice processes a nibble per cycle,
// carrying between nibbles, with valid/ready handshakes on operand and result sides.

module bit4adder (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] s,
    output logic       cout
);
    logic [3:0] g;
    logic [3:0] p;
    logic [3:0] c;

    assign g = a & b;
    assign p = a ^ b;

    // Lookahead carries, each flattened to generate/propagate terms
    assign c[0] = cin;
    assign c[1] = g[0] | (p[0] & cin);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
    assign cout = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
                | (p[3] & p[2] & p[1] & p[0] & cin);
    assign s    = p ^ c;
endmodule

module nibble_serial_adder #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
);
    localparam int unsigned NIBBLES = WIDTH / 4;
    localparam int unsigned IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               carry_q, carry_d;
    logic [WIDTH-1:0]   a_sh_q, a_sh_d;
    logic [WIDTH-1:0]   b_sh_q, b_sh_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic               cout_q, cout_d;
    logic               in_ready_q, in_ready_d;
    logic               out_valid_q, out_valid_d;
    logic               busy_q, busy_d;

    logic [3:0]         cla_s;
    logic               cla_c;

    bit4adder u_cla (
        .a    (a_sh_q[3:0]),
        .b    (b_sh_q[3:0]),
        .cin  (carry_q),
        .s    (cla_s),
        .cout (cla_c)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        sum_d   = sum_q;
        cout_d  = cout_q;

        unique case (state_q)
            IDLE: begin
                // in_ready_q gates acceptance so nothing is taken the cycle after reset release
                if (in_valid && in_ready_q) begin
                    a_sh_d  = a;
                    b_sh_d  = b;
                    carry_d = cin;
                    sum_d   = '0;
                    idx_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                carry_d = cla_c;
                sum_d   = (sum_q >> 4) | (WIDTH'(cla_s) << (WIDTH - 4));
                a_sh_d  = a_sh_q >> 4;
                b_sh_d  = b_sh_q >> 4;
                idx_d   = idx_q + IDX_W'(1);
                if (idx_q == IDX_W'(NIBBLES - 1)) begin
                    cout_d  = cla_c;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == DONE);
        busy_d      = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            carry_q     <= 1'b0;
            a_sh_q      <= '0;
            b_sh_q      <= '0;
            sum_q       <= '0;
            cout_q      <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            carry_q     <= carry_d;
            a_sh_q      <= a_sh_d;
            b_sh_q      <= b_sh_d;
            sum_q       <= sum_d;
            cout_q      <= cout_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign sum       = sum_q;
    assign cout      = cout_q;
endmodule

// File: tb/tb_nibble_serial_adder.sv
// Randomized self-checking bench for nibble_serial_adder (WIDTH=16 and WIDTH=4 instances)
// against a plain-arithmetic reference of a+b+cin.

module tb_nibble_serial_adder;
    localparam int NIB   = 4;
    localparam int BOUND = 40;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        in_valid = 1'b0, out_ready = 1'b0, cin = 1'b0;
    logic [15:0] a = '0, b = '0;
    logic        in_ready, out_valid, cout, busy;
    logic [15:0] sum;

    logic        in_valid4 = 1'b0, out_ready4 = 1'b0, cin4 = 1'b0;
    logic [3:0]  a4 = '0, b4 = '0;
    logic        in_ready4, out_valid4, cout4, busy4;
    logic [3:0]  sum4;

    int pass_cnt = 0;
    int chk_cnt  = 0;

    always #5 clk = ~clk;

    nibble_serial_adder #(.WIDTH(16)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
        .cin(cin), .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .cout(cout),
        .busy(busy)
    );

    nibble_serial_adder #(.WIDTH(4)) u_dut4 (
        .clk(clk), .rst(rst), .in_valid(in_valid4), .in_ready(in_ready4), .a(a4), .b(b4),
        .cin(cin4), .out_valid(out_valid4), .out_ready(out_ready4), .sum(sum4), .cout(cout4),
        .busy(busy4)
    );

    function automatic logic [16:0] model16(input logic [15:0] x, input logic [15:0] y, input logic c);
        return 17'(x) + 17'(y) + 17'(c);
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk_cnt++; if (in_ready !== 1'b0) $display("FAIL reset_in_ready got %b exp 0", in_ready); else pass_cnt++;
        chk_cnt++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b exp 0", out_valid); else pass_cnt++;
        chk_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy got %b exp 0", busy); else pass_cnt++;
        chk_cnt++; if ({cout, sum} !== 17'h0) $display("FAIL reset_sum got %h exp 0", {cout, sum}); else pass_cnt++;
        chk_cnt++; if (in_ready4 !== 1'b0) $display("FAIL reset_in_ready4 got %b exp 0", in_ready4); else pass_cnt++;
        #3 rst = 1'b0;
        #1;
        chk_cnt++; if (in_ready !== 1'b0) $display("FAIL release_in_ready got %b exp 0", in_ready); else pass_cnt++;
        @(posedge clk); #1;
        chk_cnt++; if (in_ready !== 1'b1) $display("FAIL post_release_in_ready got %b exp 1", in_ready); else pass_cnt++;
        chk_cnt++; if (busy !== 1'b0) $display("FAIL post_release_busy got %b exp 0", busy); else pass_cnt++;
    endtask

    task automatic test_directed();
        logic [15:0] va [3] = '{16'hFFFF, 16'h1234, 16'hFFFF};
        logic [15:0] vb [3] = '{16'h0001, 16'h4321, 16'hFFFF};
        logic        vc [3] = '{1'b0, 1'b1, 1'b1};
        logic [16:0] vexp [3] = '{17'h10000, 17'h05556, 17'h1FFFF};
        for (int i = 0; i < 3; i++) begin
            int lat = 0;
            chk_cnt++; if (in_ready !== 1'b1) $display("FAIL dir%0d_in_ready got %b exp 1", i, in_ready); else pass_cnt++;
            chk_cnt++; if (model16(va[i], vb[i], vc[i]) !== vexp[i]) $display("FAIL dir%0d_model got %h exp %h", i, model16(va[i], vb[i], vc[i]), vexp[i]); else pass_cnt++;
            in_valid = 1'b1; a = va[i]; b = vb[i]; cin = vc[i];
            @(posedge clk); #1;
            in_valid = 1'b0; a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom);
            while (!out_valid && lat < BOUND) begin
                @(posedge clk); #1; lat++;
            end
            chk_cnt++; if (lat !== NIB) $display("FAIL dir%0d_latency got %0d exp %0d", i, lat, NIB); else pass_cnt++;
            chk_cnt++; if ({cout, sum} !== vexp[i]) $display("FAIL dir%0d_result got %h exp %h", i, {cout, sum}, vexp[i]); else pass_cnt++;
            chk_cnt++; if (in_ready !== 1'b0 || busy !== 1'b1) $display("FAIL dir%0d_done_flags got rdy=%b busy=%b exp rdy=0 busy=1", i, in_ready, busy); else pass_cnt++;
            out_ready = 1'b1;
            @(posedge clk); #1;
            out_ready = 1'b0;
            chk_cnt++; if (out_valid !== 1'b0 || in_ready !== 1'b1) $display("FAIL dir%0d_release got vld=%b rdy=%b exp vld=0 rdy=1", i, out_valid, in_ready); else pass_cnt++;
        end
    endtask

    task automatic test_stall();
        logic [16:0] exp = model16(16'hA5C3, 16'h1F0E, 1'b1);
        int lat = 0;
        in_valid = 1'b1; a = 16'hA5C3; b = 16'h1F0E; cin = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        while (!out_valid && lat < BOUND) begin
            @(posedge clk); #1; lat++;
        end
        chk_cnt++; if (lat !== NIB) $display("FAIL stall_latency got %0d exp %0d", lat, NIB); else pass_cnt++;
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'($urandom); a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom);
            @(posedge clk); #1;
            chk_cnt++; if ({cout, sum} !== exp || out_valid !== 1'b1 || in_ready !== 1'b0)
                $display("FAIL stall%0d_hold got res=%h vld=%b rdy=%b exp res=%h vld=1 rdy=0", i, {cout, sum}, out_valid, in_ready, exp);
            else pass_cnt++;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk_cnt++; if (busy !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b1)
            $display("FAIL stall_release got busy=%b vld=%b rdy=%b exp busy=0 vld=0 rdy=1", busy, out_valid, in_ready);
        else pass_cnt++;
    endtask

    task automatic test_async_reset();
        logic [16:0] exp = model16(16'h0F0F, 16'h00F1, 1'b1);
        int lat = 0;
        in_valid = 1'b1; a = 16'h8888; b = 16'h7777; cin = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk_cnt++; if (busy !== 1'b0 || out_valid !== 1'b0 || sum !== 16'h0 || cout !== 1'b0 || in_ready !== 1'b0)
            $display("FAIL rst_run got busy=%b vld=%b sum=%h cout=%b rdy=%b exp all 0", busy, out_valid, sum, cout, in_ready);
        else pass_cnt++;
        #2 rst = 1'b0;
        @(posedge clk); #1;
        chk_cnt++; if (in_ready !== 1'b1) $display("FAIL rst_run_rdy got %b exp 1", in_ready); else pass_cnt++;
        in_valid = 1'b1; a = 16'h0F0F; b = 16'h00F1; cin = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        while (!out_valid && lat < BOUND) begin
            @(posedge clk); #1; lat++;
        end
        chk_cnt++; if (lat !== NIB || {cout, sum} !== exp) $display("FAIL rst_fresh got lat=%0d res=%h exp lat=%0d res=%h", lat, {cout, sum}, NIB, exp); else pass_cnt++;
        #3 rst = 1'b1;
        #1;
        chk_cnt++; if (out_valid !== 1'b0 || sum !== 16'h0 || busy !== 1'b0)
            $display("FAIL rst_done got vld=%b sum=%h busy=%b exp 0", out_valid, sum, busy);
        else pass_cnt++;
        #2 rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        for (int n = 0; n < 1000; n++) begin
            logic [15:0] ra = 16'($urandom);
            logic [15:0] rb = 16'($urandom);
            logic        rc = 1'($urandom);
            logic [16:0] exp;
            int stall = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0;
            int lat = 0;
            int w = 0;
            if (n % 7 == 0) begin
                ra = 16'hFFFF; rb = 16'hFFFF; rc = 1'b1;
            end
            exp = model16(ra, rb, rc);
            while (!in_ready && w < BOUND) begin
                @(posedge clk); #1; w++;
            end
            out_ready = (stall == 0);
            in_valid = 1'b1; a = ra; b = rb; cin = rc;
            @(posedge clk); #1;
            in_valid = 1'($urandom); a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom);
            while (!out_valid && lat < BOUND) begin
                @(posedge clk); #1; lat++;
            end
            in_valid = 1'b0;
            chk_cnt++; if (lat !== NIB) $display("FAIL b2b%0d_latency got %0d exp %0d", n, lat, NIB); else pass_cnt++;
            repeat (stall) begin
                @(posedge clk); #1;
            end
            chk_cnt++; if ({cout, sum} !== exp || out_valid !== 1'b1)
                $display("FAIL b2b%0d_result got res=%h vld=%b exp res=%h vld=1", n, {cout, sum}, out_valid, exp);
            else pass_cnt++;
            out_ready = 1'b1;
            @(posedge clk); #1;
            out_ready = 1'b0;
            chk_cnt++; if (out_valid !== 1'b0 || in_ready !== 1'b1)
                $display("FAIL b2b%0d_release got vld=%b rdy=%b exp vld=0 rdy=1", n, out_valid, in_ready);
            else pass_cnt++;
        end
    endtask

    task automatic test_width4();
        for (int i = 0; i < 9; i++) begin
            logic [3:0] ra = (i == 0) ? 4'hF : 4'($urandom);
            logic [3:0] rb = (i == 0) ? 4'h1 : 4'($urandom);
            logic       rc = (i == 0) ? 1'b0 : 1'($urandom);
            logic [4:0] exp = 5'(ra) + 5'(rb) + 5'(rc);
            chk_cnt++; if (in_ready4 !== 1'b1) $display("FAIL w4_%0d_in_ready got %b exp 1", i, in_ready4); else pass_cnt++;
            in_valid4 = 1'b1; a4 = ra; b4 = rb; cin4 = rc;
            @(posedge clk); #1;
            in_valid4 = 1'b0;
            chk_cnt++; if (out_valid4 !== 1'b0 || busy4 !== 1'b1) $display("FAIL w4_%0d_run got vld=%b busy=%b exp vld=0 busy=1", i, out_valid4, busy4); else pass_cnt++;
            @(posedge clk); #1;
            chk_cnt++; if (out_valid4 !== 1'b1 || {cout4, sum4} !== exp)
                $display("FAIL w4_%0d_result got vld=%b res=%h exp vld=1 res=%h", i, out_valid4, {cout4, sum4}, exp);
            else pass_cnt++;
            out_ready4 = 1'b1;
            @(posedge clk); #1;
            out_ready4 = 1'b0;
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_stall();
        test_async_reset();
        test_back_to_back();
        test_width4();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule
